// File: rtl/sa_tile_sched_if.sv
// sa_tile_sched_if: handshake bundle between the tile scheduler and its surroundings
// master: scheduler side (drives cmd_ready, src_req, core_inpvalid, core_outread, done_*, busy)
// slave : environment side (drives cmd_*, src_valid, core_rvalid, done_ready)
interface sa_tile_sched_if #(
    parameter int ROWS = 8,
    parameter int KW   = 16,
    parameter int IDW  = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [KW-1:0]   cmd_k;
    logic [IDW-1:0]  cmd_id;
    logic            src_req;
    logic            src_valid;
    logic            core_inpvalid;
    logic [ROWS-1:0] core_rvalid;
    logic            core_outread;
    logic            done_valid;
    logic            done_ready;
    logic [IDW-1:0]  done_id;
    logic            done_err;
    logic            busy;
    modport master (
        input  cmd_valid, cmd_k, cmd_id, src_valid, core_rvalid, done_ready,
        output cmd_ready, src_req, core_inpvalid, core_outread, done_valid, done_id, done_err, busy
    );
    modport slave (
        output cmd_valid, cmd_k, cmd_id, src_valid, core_rvalid, done_ready,
        input  cmd_ready, src_req, core_inpvalid, core_outread, done_valid, done_id, done_err, busy
    );
endinterface

// File: rtl/sa_tile_sched.sv
// sa_tile_sched: sequences one systolic-array tile operation (load K beats, flush, drain, complete)
// clk, rst       : clock, synchronous active-high reset
// bus            : sa_tile_sched_if.master (command, source, core and completion handshakes)
// o_perf_cyc     : cycles from acceptance to done_valid rise (only with SA_SCHED_PERF_EN)
// o_perf_stall   : LOAD cycles without src_valid (only with SA_SCHED_PERF_EN)
module sa_tile_sched #(
    parameter int ROWS      = 8,
    parameter int KW        = 16,
    parameter int IDW       = 4,
    parameter int FLUSH_CYC = 2 * ROWS,
    parameter int TIMEOUT   = 1024
) (
    input logic clk,
    input logic rst,
    sa_tile_sched_if.master bus
`ifdef SA_SCHED_PERF_EN
    ,
    output logic [31:0] o_perf_cyc,
    output logic [31:0] o_perf_stall
`endif
);
    localparam int TW = $clog2((FLUSH_CYC > TIMEOUT ? FLUSH_CYC : TIMEOUT) + 1);
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;
    state_t         r_state, w_next;
    logic           r_rdy, r_err, w_err;
    logic [KW-1:0]  r_k, r_beat;
    logic [IDW-1:0] r_id;
    logic [TW-1:0]  r_tmr;
    logic           w_acc, w_beat, w_last, w_full, w_flush_end, w_tmo;
    // r_rdy holds cmd_ready low for the first cycle after reset
    assign w_acc       = r_state == IDLE && r_rdy && bus.cmd_valid;
    assign w_beat      = r_state == LOAD && bus.src_valid;
    assign w_last      = w_beat && r_beat == r_k - KW'(1);
    assign w_full      = r_state == DRAIN && &bus.core_rvalid;
    assign w_flush_end = r_state == FLUSH && r_tmr == TW'(FLUSH_CYC - 1);
    assign w_tmo       = r_state == DRAIN && !w_full && r_tmr == TW'(TIMEOUT - 1);
    always_comb begin
        w_next = r_state;
        w_err  = r_err;
        case (r_state)
            IDLE:    if (w_acc) begin
                         w_next = bus.cmd_k == '0 ? DONE : LOAD;
                         w_err  = bus.cmd_k == '0;
                     end
            LOAD:    w_next = w_last ? FLUSH : LOAD;
            FLUSH:   w_next = w_flush_end ? DRAIN : FLUSH;
            DRAIN:   if (w_full || w_tmo) begin
                         w_next = DONE;
                         w_err  = w_tmo;
                     end
            DONE:    w_next = bus.done_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
            r_k     <= '0;
            r_id    <= '0;
            r_beat  <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_next;
            r_rdy   <= 1'b1;
            r_err   <= w_err;
            if (w_acc) begin
                r_k  <= bus.cmd_k;
                r_id <= bus.cmd_id;
            end
            r_beat <= w_last ? '0 : w_beat ? r_beat + KW'(1) : r_beat;
            // one timer serves FLUSH and DRAIN; it saturates instead of wrapping
            r_tmr  <= (w_flush_end || r_state == IDLE || r_state == LOAD || r_state == DONE) ? '0
                    : r_tmr + TW'(r_tmr != '1);
        end
    end
    assign bus.cmd_ready     = r_state == IDLE && r_rdy;
    assign bus.src_req       = r_state == LOAD;
    assign bus.core_inpvalid = w_beat;
    assign bus.core_outread  = w_full;
    assign bus.done_valid    = r_state == DONE;
    assign bus.done_id       = r_state == DONE ? r_id : '0;
    assign bus.done_err      = r_state == DONE && r_err;
    assign bus.busy          = r_state != IDLE;
`ifdef SA_SCHED_PERF_EN
    logic [31:0] r_run;
    // r_run is the number of cycles elapsed since the acceptance cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run        <= '0;
            o_perf_cyc   <= '0;
            o_perf_stall <= '0;
        end else if (w_acc) begin
            r_run        <= 32'd1;
            o_perf_stall <= '0;
            o_perf_cyc   <= bus.cmd_k == '0 ? 32'd1 : 32'd0;
        end else begin
            if (r_state == LOAD || r_state == FLUSH || r_state == DRAIN)
                r_run <= r_run + 32'(r_run != '1);
            if (r_state == DRAIN && w_next == DONE)
                o_perf_cyc <= r_run + 32'(r_run != '1);
            if (r_state == LOAD && !bus.src_valid)
                o_perf_stall <= o_perf_stall + 32'(o_perf_stall != '1);
        end
    end
`endif
endmodule

// File: tb/tb_sa_tile_sched.sv
// tb_sa_tile_sched: randomized self-checking bench for sa_tile_sched against a timeline model
module tb_sa_tile_sched;
    localparam int ROWS = 8;
    localparam int KW = 16;
    localparam int IDW = 4;
    localparam int F = 2 * ROWS;
    localparam int TMO = 1024;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int pat[$];
    logic [31:0] perf_cyc, perf_stall;
    sa_tile_sched_if #(.ROWS(ROWS), .KW(KW), .IDW(IDW)) bus ();
    sa_tile_sched #(.ROWS(ROWS), .KW(KW), .IDW(IDW), .FLUSH_CYC(F), .TIMEOUT(TMO)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SA_SCHED_PERF_EN
        ,
        .o_perf_cyc(perf_cyc),
        .o_perf_stall(perf_stall)
`endif
    );
`ifndef SA_SCHED_PERF_EN
    assign perf_cyc = '0;
    assign perf_stall = '0;
`endif
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 0);
        chk({tag, ".src_req"}, 32'(bus.src_req), 0);
        chk({tag, ".inpvalid"}, 32'(bus.core_inpvalid), 0);
        chk({tag, ".outread"}, 32'(bus.core_outread), 0);
        chk({tag, ".done_valid"}, 32'(bus.done_valid), 0);
        chk({tag, ".done_id"}, 32'(bus.done_id), 0);
        chk({tag, ".done_err"}, 32'(bus.done_err), 0);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
`ifdef SA_SCHED_PERF_EN
        chk({tag, ".perf_cyc"}, perf_cyc, 0);
        chk({tag, ".perf_stall"}, perf_stall, 0);
`endif
    endtask
    // One command: accept at cycle 0; model tracks beats seen, then derives the
    // flush window and drain end from plain cycle arithmetic.
    // delay < 0 keeps core_rvalid at 'stuck' for the whole drain.
    task automatic run_cmd(input int k, input logic [IDW-1:0] id, input int pct,
                           input int delay, input logic [ROWS-1:0] stuck, input int hold);
        int beats = 0, t_last = 0, de = 0, d0;
        logic fin = 1'b0, err, ld, s, indrain, full, tmo;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_k = KW'(k); bus.cmd_id = id; bus.done_ready = 1'b0;
        bus.src_valid = 1'($urandom_range(1)); bus.core_rvalid = ROWS'($urandom_range(255));
        @(negedge clk);
        chk("accept.cmd_ready", 32'(bus.cmd_ready), 1);
        chk("accept.busy", 32'(bus.busy), 0);
        err = (k == 0);
        fin = (k == 0);
        for (int c = 1; c < 6000 && !fin; c++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'($urandom_range(1)); bus.cmd_id = ~id; bus.cmd_k = KW'($urandom);
            ld = (t_last == 0);
            s = ld ? (pat.size() > 0 ? 1'(pat.pop_front()) : ($urandom_range(99) < pct)) : 1'($urandom_range(1));
            bus.src_valid = s;
            d0 = t_last + F + 1;
            indrain = (t_last != 0) && (c >= d0);
            full = indrain && delay >= 0 && c >= d0 + delay;
            tmo = indrain && !full && c == d0 + TMO - 1;
            bus.core_rvalid = full ? '1 : indrain ? (delay < 0 ? stuck : ROWS'($urandom_range(254)))
                            : ROWS'($urandom_range(255));
            @(negedge clk);
            chk("run.src_req", 32'(bus.src_req), 32'(ld));
            chk("run.inpvalid", 32'(bus.core_inpvalid), 32'(ld && s));
            chk("run.outread", 32'(bus.core_outread), 32'(full));
            chk("run.busy", 32'(bus.busy), 1);
            chk("run.cmd_ready", 32'(bus.cmd_ready), 0);
            chk("run.done_valid", 32'(bus.done_valid), 0);
            if (ld && s) begin
                beats++;
                if (beats == k) t_last = c;
            end
            if (full || tmo) begin
                de = c;
                err = tmo;
                fin = 1'b1;
            end
        end
        if (!fin) chk("run.bound", 0, 1);
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            bus.done_ready = (h == hold);
            bus.cmd_valid = 1'($urandom_range(1)); bus.cmd_id = ~id; bus.cmd_k = KW'($urandom);
            bus.src_valid = 1'($urandom_range(1)); bus.core_rvalid = ROWS'($urandom_range(255));
            @(negedge clk);
            chk("done.valid", 32'(bus.done_valid), 1);
            chk("done.id", 32'(bus.done_id), 32'(id));
            chk("done.err", 32'(bus.done_err), 32'(err));
            chk("done.cmd_ready", 32'(bus.cmd_ready), 0);
            chk("done.busy", 32'(bus.busy), 1);
            chk("done.src_req", 32'(bus.src_req), 0);
            chk("done.outread", 32'(bus.core_outread), 0);
`ifdef SA_SCHED_PERF_EN
            chk("done.perf_cyc", perf_cyc, 32'(de + 1));
            chk("done.perf_stall", perf_stall, k == 0 ? 0 : 32'(t_last - k));
`endif
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.done_ready = 1'b0;
        @(negedge clk);
        chk("idle.busy", 32'(bus.busy), 0);
        chk("idle.cmd_ready", 32'(bus.cmd_ready), 1);
        chk("idle.done_valid", 32'(bus.done_valid), 0);
    endtask
    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_k = '0; bus.cmd_id = '0; bus.src_valid = 1'b0;
        bus.core_rvalid = '0; bus.done_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset.ready_after", 32'(bus.cmd_ready), 1);
        run_cmd(4, 4'h3, 100, 0, '0, 0);
        pat = '{1, 0, 0, 1, 1};
        run_cmd(3, 4'h9, 100, 2, '0, 1);
        run_cmd(0, 4'h5, 100, 0, '0, 0);
        run_cmd(2, 4'hA, 100, -1, 8'h7F, 0);
        run_cmd(5, 4'hC, 60, 3, '0, 10);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_k = KW'(10); bus.cmd_id = 4'h6;
        @(negedge clk);
        chk("midrst.accept", 32'(bus.cmd_ready), 1);
        repeat (5) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0; bus.src_valid = 1'b1;
            @(negedge clk);
            chk("midrst.inpvalid", 32'(bus.core_inpvalid), 1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        run_cmd(2, 4'h1, 100, 1, '0, 0);
        for (int i = 0; i < 4; i++)
            run_cmd(int'($urandom_range(12, 1)), IDW'($urandom), int'($urandom_range(100, 30)),
                    int'($urandom_range(20)), '0, int'($urandom_range(3)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
